dcm_lock_ctrl: RTL and testbench

//  Consumes the frequency-measurement results (word, mode, out-of-range, set) for the DCM input clock and sequences DCM bring-up.

---
 rtl/dcm_lock_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dcm_lock_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_lock_ctrl.sv
// DCM bring-up sequencer: settle on a valid frequency measurement, pulse DCM reset, wait for lock, supervise.
// Optional macro DCM_FREQ_TRACK_EN adds a run-time drift check of I_freq_word against the captured word.
module dcm_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned FREQ_TOL      = 1000000
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic [31:0] I_freq_word,
    input  logic        I_freq_mode,
    input  logic        I_freq_or,
    input  logic        I_freq_set,
    input  logic        I_dcm_locked,
    output logic        O_dcm_reset,
    output logic        O_dcm_mode,
    output logic        O_ready,
    output logic        O_fault,
    output logic [2:0]  O_state,
    output logic [7:0]  O_relock_count
);
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        WAIT_FREQ = 3'd0,
        RESET_DCM = 3'd1,
        WAIT_LOCK = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [7:0]       retries;
    logic [7:0]       retry_next;
    logic             lock_meta;
    logic             locked_s;
    logic             freq_ok;
    logic             settle_done;
    logic             track_viol;
    logic             run_exit;

    // LOCKED is asynchronous to the reference clock
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= I_dcm_locked;
            locked_s  <= lock_meta;
        end
    end

    assign freq_ok     = I_freq_set & ~I_freq_or;
    assign settle_done = (state == WAIT_FREQ) && freq_ok && (count == SETTLE_LAST);
    assign retry_next  = retries + 8'd1;
    assign O_state     = 3'(state);

`ifdef DCM_FREQ_TRACK_EN
    logic [31:0]        captured;
    logic signed [32:0] word_diff;
    logic [32:0]        word_mag;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            captured <= 32'd0;
        end else if (settle_done) begin
            captured <= I_freq_word;
        end
    end

    assign word_diff  = $signed({1'b0, I_freq_word}) - $signed({1'b0, captured});
    assign word_mag   = word_diff[32] ? $unsigned(-word_diff) : $unsigned(word_diff);
    assign track_viol = word_mag > 33'(FREQ_TOL);
`else
    logic [31:0] track_unused;
    assign track_unused = I_freq_word ^ 32'(FREQ_TOL);
    assign track_viol   = 1'b0;
`endif

    assign run_exit = ~locked_s | ~freq_ok | (I_freq_mode != O_dcm_mode) | track_viol;

    // Sequencer; outputs are loaded together with the state they belong to
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state          <= WAIT_FREQ;
            count          <= '0;
            retries        <= 8'd0;
            O_dcm_reset    <= 1'b1;
            O_dcm_mode     <= 1'b0;
            O_ready        <= 1'b0;
            O_fault        <= 1'b0;
            O_relock_count <= 8'd0;
        end else begin
            case (state)
                WAIT_FREQ: begin
                    if (settle_done) begin
                        state      <= RESET_DCM;
                        count      <= '0;
                        O_dcm_mode <= I_freq_mode;
                    end else if (freq_ok) begin
                        count <= count + 32'd1;
                    end else begin
                        count <= '0;
                    end
                end
                RESET_DCM: begin
                    if (count == RST_LAST) begin
                        state       <= WAIT_LOCK;
                        count       <= '0;
                        O_dcm_reset <= 1'b0;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (!freq_ok) begin
                        state       <= WAIT_FREQ;
                        count       <= '0;
                        retries     <= 8'd0;
                        O_dcm_reset <= 1'b1;
                    end else if (locked_s) begin
                        state   <= RUN;
                        count   <= '0;
                        retries <= 8'd0;
                        O_ready <= 1'b1;
                    end else if (count == TIMEOUT_LAST) begin
                        count       <= '0;
                        retries     <= retry_next;
                        O_dcm_reset <= 1'b1;
                        if (retry_next == RETRY_LIMIT) begin
                            state   <= FAULT;
                            O_fault <= 1'b1;
                        end else begin
                            state <= RESET_DCM;
                        end
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        state       <= WAIT_FREQ;
                        count       <= '0;
                        O_ready     <= 1'b0;
                        O_dcm_reset <= 1'b1;
                        if (O_relock_count != 8'hFF) begin
                            O_relock_count <= O_relock_count + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    O_fault     <= 1'b1;
                    O_dcm_reset <= 1'b1;
                    O_ready     <= 1'b0;
                end
                default: begin
                    state       <= WAIT_FREQ;
                    count       <= '0;
                    retries     <= 8'd0;
                    O_dcm_reset <= 1'b1;
                    O_ready     <= 1'b0;
                    O_fault     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Bench for dcm_lock_ctrl: directed bring-up scenarios plus randomized traffic against a behavioural model.
module tb_dcm_lock_ctrl;
    localparam int RST_N    = 4;
    localparam int SETTLE_N = 20;
    localparam int TIMEOUT  = 30;
    localparam int MAXR     = 3;
    localparam int TOL      = 1000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] freq_word;
    logic        freq_mode;
    logic        freq_or;
    logic        freq_set;
    logic        dcm_locked;
    logic        dcm_reset;
    logic        dcm_mode;
    logic        ready;
    logic        fault;
    logic [2:0]  state;
    logic [7:0]  relock_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    dcm_lock_ctrl #(
        .RST_CYCLES(RST_N), .SETTLE_CYCLES(SETTLE_N), .LOCK_TIMEOUT(TIMEOUT),
        .MAX_RETRIES(MAXR), .FREQ_TOL(TOL)
    ) dut (
        .I_clk(clk), .I_reset(reset), .I_freq_word(freq_word), .I_freq_mode(freq_mode),
        .I_freq_or(freq_or), .I_freq_set(freq_set), .I_dcm_locked(dcm_locked),
        .O_dcm_reset(dcm_reset), .O_dcm_mode(dcm_mode), .O_ready(ready), .O_fault(fault),
        .O_state(state), .O_relock_count(relock_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase (0..4 as in O_state), cycles spent in the phase, valid streak
    int          m_state = 0;
    int          in_phase = 0;
    int          streak = 0;
    int          m_ret = 0;
    int          m_relock = 0;
    bit          m_mode = 1'b0;
    bit   [31:0] m_cap = 32'd0;
    bit          hist1 = 1'b0;
    bit          hist2 = 1'b0;
    bit          e_rst = 1'b1;

    always @(posedge clk) begin
        bit     ls;
        bit     ok;
        bit     drift;
        int     nxt;
        longint dd;
        ls    = hist2;
        hist2 = hist1;
        hist1 = dcm_locked;
        ok    = freq_set && !freq_or;
        dd    = longint'(freq_word) - longint'(m_cap);
        if (dd < 0) dd = -dd;
`ifdef DCM_FREQ_TRACK_EN
        drift = dd > longint'(TOL);
`else
        drift = 1'b0;
`endif
        if (reset) begin
            m_state = 0; in_phase = 0; streak = 0; m_ret = 0; m_relock = 0;
            m_mode = 1'b0; m_cap = 32'd0; hist1 = 1'b0; hist2 = 1'b0;
        end else begin
            nxt = m_state;
            in_phase++;
            case (m_state)
                0: begin
                    streak = ok ? streak + 1 : 0;
                    if (streak == SETTLE_N) begin
                        nxt = 1; m_mode = freq_mode; m_cap = freq_word;
                    end
                end
                1: if (in_phase == RST_N) nxt = 2;
                2: begin
                    if (!ok) begin nxt = 0; m_ret = 0; end
                    else if (ls) begin nxt = 3; m_ret = 0; end
                    else if (in_phase == TIMEOUT) begin
                        m_ret++;
                        nxt = (m_ret == MAXR) ? 4 : 1;
                    end
                end
                3: if (!ls || !ok || (freq_mode != m_mode) || drift) begin
                    nxt = 0;
                    if (m_relock < 255) m_relock++;
                end
                default: ;
            endcase
            if (nxt != m_state) begin in_phase = 0; streak = 0; end
            m_state = nxt;
        end
        e_rst = !(m_state == 2 || m_state == 3);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("dcm_reset", 32'(dcm_reset), 32'(e_rst));
            chk("ready", 32'(ready), 32'(m_state == 3));
            chk("fault", 32'(fault), 32'(m_state == 4));
            chk("dcm_mode", 32'(dcm_mode), 32'(m_mode));
            chk("relock_count", 32'(relock_count), 32'(m_relock));
        end
    end

    // LOCKED source: 0 forced low, 1 forced high, 2 rises a delay after DCM reset falls
    int lock_mode = 0;
    int fixed_delay = 10;
    bit rand_delay = 1'b0;
    bit rand_drop = 1'b0;
    int lk_cnt = 0;
    int lk_delay = 10;

    always @(negedge clk) begin
        #1;
        if (e_rst) begin
            lk_cnt   = 0;
            lk_delay = rand_delay ? int'($urandom_range(1, 36)) : fixed_delay;
        end else begin
            lk_cnt++;
        end
        case (lock_mode)
            0: dcm_locked = 1'b0;
            1: dcm_locked = 1'b1;
            default: dcm_locked = (lk_cnt >= lk_delay) && !(rand_drop && ($urandom_range(0, 299) == 0));
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int max_n, output int n);
        n = 0;
        while (state != 3'(s) && n < max_n) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int attempts;
        logic [2:0] prev;
        reset = 1'b1; freq_set = 1'b0; freq_or = 1'b0; freq_mode = 1'b0;
        freq_word = 32'd0; dcm_locked = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_dcm_reset", 32'(dcm_reset), 1);
        chk("rst_ready", 32'(ready), 0);

        // Nominal bring-up with one out-of-range glitch during settling
        reset = 1'b0; freq_set = 1'b1; freq_mode = 1'b1; freq_word = 32'd200_000_000;
        lock_mode = 2; fixed_delay = 10;
        tick(10);
        freq_or = 1'b1;
        tick(1);
        freq_or = 1'b0;
        wait_state(1, 100, n);
        chk("settle_len_after_glitch", 32'(n), 20);
        chk("mode_latched", 32'(dcm_mode), 1);
        wait_state(2, 50, n);
        chk("reset_pulse_len", 32'(n), 4);
        wait_state(3, 100, n);
        chk("lock_to_run", 32'(n), 12);
        chk("ready_in_run", 32'(ready), 1);
        chk("relock_zero", 32'(relock_count), 0);

        // One-cycle lock loss in RUN
        tick(5);
        lock_mode = 0;
        tick(1);
        lock_mode = 2;
        wait_state(0, 10, n);
        chk("lockloss_relock", 32'(relock_count), 1);
        chk("lockloss_dcm_reset", 32'(dcm_reset), 1);
        wait_state(3, 200, n);
        chk("lockloss_ready_back", 32'(ready), 1);

        // Mode change 1->0 then 0->1
        freq_mode = 1'b0; freq_word = 32'd140_000_000;
        tick(1);
        chk("mode_exit_a", 32'(state), 0);
        wait_state(3, 200, n);
        chk("mode_low_applied", 32'(dcm_mode), 0);
        freq_mode = 1'b1; freq_word = 32'd160_000_000;
        tick(1);
        chk("mode_exit_b", 32'(state), 0);
        chk("mode_relock", 32'(relock_count), 3);
        wait_state(3, 200, n);
        chk("mode_high_applied", 32'(dcm_mode), 1);

        // Frequency drift around the tolerance boundary, captured 100e6
        freq_word = 32'd100_000_000; freq_set = 1'b0;
        tick(1);
        freq_set = 1'b1;
        wait_state(3, 200, n);
        chk("drift_setup_run", 32'(state), 3);
        freq_word = 32'd101_000_000;
        tick(5);
        chk("drift_at_tol", 32'(state), 3);
        freq_word = 32'd101_000_001;
        tick(2);
`ifdef DCM_FREQ_TRACK_EN
        chk("drift_over_tol", 32'(state), 0);
`else
        chk("drift_over_tol", 32'(state), 3);
`endif

        // Lock timeout, reset mid-count, then retries exhausted
        lock_mode = 0;
        wait_state(2, 200, n);
        wait_state(1, 100, n);
        chk("timeout_len", 32'(n), 30);
        wait_state(2, 50, n);
        tick(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midreset_state", 32'(state), 0);
        chk("midreset_dcm_reset", 32'(dcm_reset), 1);
        chk("midreset_mode", 32'(dcm_mode), 0);
        chk("midreset_relock", 32'(relock_count), 0);
        attempts = 0;
        prev = state;
        n = 0;
        while (state != 3'd4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (prev != 3'd1 && state == 3'd1) attempts++;
            prev = state;
        end
        chk("retry_attempts", 32'(attempts), 3);
        chk("fault_set", 32'(fault), 1);
        lock_mode = 1;
        tick(40);
        chk("fault_sticky", 32'(state), 4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("fault_cleared", 32'(fault), 0);

        // Randomized traffic
        lock_mode = 2; rand_delay = 1'b1; rand_drop = 1'b1;
        freq_word = 32'd100_000_000;
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 999) == 0);
            freq_set = ($urandom_range(0, 59) != 0);
            freq_or  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 249) == 0) freq_mode = ~freq_mode;
            if ($urandom_range(0, 19) == 0) freq_word = 32'(100_000_000 + $urandom_range(0, 3_000_000));
            tick(1);
        end

        // Relock counter saturation
        reset = 1'b1; freq_set = 1'b1; freq_or = 1'b0; freq_mode = 1'b0;
        lock_mode = 1; rand_delay = 1'b0; rand_drop = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int k = 0; k < 260; k++) begin
            wait_state(3, 200, n);
            if (state != 3'd3) begin
                chk("sat_reach_run", 32'(state), 3);
                break;
            end
            freq_set = 1'b0;
            tick(1);
            freq_set = 1'b1;
        end
        chk("relock_saturated", 32'(relock_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
